// File: rtl/iterative_shifter_pkg.sv
// Shared types and constants for the iterative shifter: FSM states, direction codes, default width.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package shifter_pkg;

    // Default datapath width; must be a power of two, at least 2.
    localparam int DEFAULT_WIDTH = 32;

    // Direction encoding shared with the combinational shifter stages.
    localparam logic SH_LEFT  = 1'b0;
    localparam logic SH_RIGHT = 1'b1;

    // Request lifecycle: wait for START, walk the stages, present the result for one cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE_S = 2'd2
    } state_t;

endpackage

// File: rtl/iterative_shifter_stage.sv
// One binary-weighted shift stage: shifts the operand by 2^k or passes it through when disabled.
// Latency: purely combinational.
// Backpressure: none; the caller sequences k and holds the operand.
// Build option ITERATIVE_SHIFTER_ROTATE_EN adds i_rot, which wraps bits around instead of filling.
module shift_stage_var
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = DEFAULT_WIDTH,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_k,
    input  logic               i_en,
    input  logic               i_dir,
    input  logic               i_fill,
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    input  logic               i_rot,
`endif
    output logic [WIDTH-1:0]   o_data
);

    // Stage distance 2^k and its complement; one extra bit so WIDTH itself is representable.
    logic [SHAMT_W:0]   w_amt;
    logic [SHAMT_W:0]   w_namt;

    // Candidate shifted values and the bits that enter at the vacated end.
    logic [WIDTH-1:0]   w_left;
    logic [WIDTH-1:0]   w_right;
    logic [WIDTH-1:0]   w_rfill;
    logic [WIDTH-1:0]   w_rwrap;
    logic [WIDTH-1:0]   w_lwrap;
    logic [WIDTH-1:0]   w_rtop;
    logic [WIDTH-1:0]   w_lbot;

    assign w_amt   = (SHAMT_W + 1)'(1) << i_k;
    assign w_namt  = (SHAMT_W + 1)'(WIDTH) - w_amt;

    assign w_left  = i_data << w_amt;
    assign w_right = i_data >> w_amt;

    // Fill mask for right shifts: the top 2^k bits take the fill value.
    assign w_rfill = {WIDTH{i_fill}} << w_namt;

    // Bits that fall off one end, relocated to the other end for rotation.
    assign w_rwrap = i_data << w_namt;
    assign w_lwrap = i_data >> w_namt;

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    // Rotation replaces the fill (right) and the zero fill (left) with the wrapped bits.
    assign w_rtop = i_rot ? w_rwrap : w_rfill;
    assign w_lbot = i_rot ? w_lwrap : '0;
`else
    // Shift-only build: wrapped bits are never used.
    assign w_rtop = w_rfill;
    assign w_lbot = '0;
`endif

    // Select the direction for this stage, or pass through when its SHAMT bit is clear.
    always_comb begin
        o_data = i_data;
        if (i_en) begin
            if (i_dir == SH_RIGHT) begin
                o_data = w_right | w_rtop;
            end else begin
                o_data = w_left | w_lbot;
            end
        end
    end

    // The wrap terms are computed unconditionally; keep them referenced in the shift-only build.
    logic w_unused;
    assign w_unused = ^{w_rwrap, w_lwrap};

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shift unit: one binary-weighted stage per clock, start/done handshake.
// Latency: fixed SHAMT_W+1 cycles from accepted START to DONE, independent of SHAMT.
// Backpressure: START is only honoured in IDLE; requests arriving while BUSY are dropped.
// Build option ITERATIVE_SHIFTER_ROTATE_EN adds the ROT input (rotate instead of shift).
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = DEFAULT_WIDTH,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               START,
    input  logic               SH_DIR,
    input  logic               NEG,
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    input  logic               ROT,
`endif
    input  logic [SHAMT_W-1:0] SHAMT,
    input  logic [WIDTH-1:0]   DATA_IN,
    output logic               BUSY,
    output logic               DONE,
    output logic [WIDTH-1:0]   RESULT
);

    // Index of the final stage; reaching it ends the SHIFT phase.
    localparam logic [SHAMT_W-1:0] LAST_K = SHAMT_W'(SHAMT_W - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_work;
    logic [WIDTH-1:0]     r_result;
    logic [SHAMT_W-1:0]   r_shamt;
    logic [SHAMT_W-1:0]   r_k;
    logic                 r_dir;
    logic                 r_neg;
    logic                 r_busy;
    logic                 r_done;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    logic                 r_rot;
`endif

    logic [WIDTH-1:0]     w_stage_out;
    logic                 w_stage_en;

    // Stage k is applied only when the matching bit of the latched amount is set.
    assign w_stage_en = r_shamt[r_k];

    shift_stage_var #(
        .WIDTH  (WIDTH)
    ) u_stage (
        .i_data (r_work),
        .i_k    (r_k),
        .i_en   (w_stage_en),
        .i_dir  (r_dir),
        .i_fill (r_neg),
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
        .i_rot  (r_rot),
`endif
        .o_data (w_stage_out)
    );

    // Request FSM: capture on START, apply one stage per cycle, pulse DONE once, return to IDLE.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state  <= IDLE;
            r_work   <= '0;
            r_result <= '0;
            r_shamt  <= '0;
            r_k      <= '0;
            r_dir    <= SH_LEFT;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
            r_rot    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_work  <= DATA_IN;
                        r_shamt <= SHAMT;
                        r_dir   <= SH_DIR;
                        r_neg   <= NEG;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
                        r_rot   <= ROT;
`endif
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Every stage is visited even when its bit is clear, so latency never varies.
                    r_work <= w_stage_out;
                    r_k    <= r_k + 1'b1;
                    if (r_k == LAST_K) begin
                        r_result <= w_stage_out;
                        r_done   <= 1'b1;
                        r_state  <= DONE_S;
                    end
                end
                DONE_S: begin
                    // START seen here is deliberately ignored; the next request needs IDLE.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign RESULT = r_result;

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
- Multi-cycle 32-bit shift unit with a start/done handshake.
- Applies one binary-weighted shift stage per clock (1, 2, 4, 8, 16) instead of a full combinational barrel.
- Sits beside the datapath ALU and serves shift instructions when area matters more than latency.
- Same SH_DIR/NEG semantics as the combinational shifter stages: SH_DIR=1 right, NEG=1 fills ones on right shift.

Parameters:
- WIDTH, 32, data width; must be a power of two, at least 2.
- SHAMT_W, $clog2(WIDTH), shift-amount width and number of stages. Derived; not overridden.

Ports:
- CLK  input  1  clock, rising-edge active.
- RST_n  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE.
- SH_DIR  input  1  1 = shift right, 0 = shift left; captured on accepted START.
- NEG  input  1  right-shift fill value (1 fills ones, 0 fills zeros); ignored on left shifts; captured on START.
- SHAMT  input  SHAMT_W  shift amount 0..WIDTH-1; captured on START.
- DATA_IN  input  WIDTH  operand; captured on START.
- BUSY  output  1  high while a request is in progress (SHIFT or DONE_S).
- DONE  output  1  one-cycle pulse; RESULT is valid.
- RESULT  output  WIDTH  shifted value; holds until the next accepted START.

Behaviour:
- Reset: asynchronous, active-low, effective immediately whenever RST_n=0, including mid-operation.
  - State goes to IDLE.
  - BUSY=0, DONE=0, RESULT=0.
  - Internal operand, amount and stage counter are cleared.
- States:
  - IDLE: START=1 at an edge loads the working register from DATA_IN and latches SH_DIR, NEG and SHAMT. Stage counter k=0. Next state SHIFT, BUSY=1.
  - SHIFT: each edge, if SHAMT[k]=1, shift the working register by 2^k, then k=k+1. After stage SHAMT_W-1, next state DONE_S.
  - DONE_S: DONE=1 and BUSY=1 for exactly one cycle. RESULT equals the working register. Next state IDLE.
- Fixed latency:
  - START accepted at edge t0; stages applied at edges t1..t5 (WIDTH=32).
  - DONE high in the cycle after edge t5; back in IDLE after edge t6.
  - No early exit: SHAMT=0 takes the same latency.
- Right shift by n: result = operand >> n; the top n bits equal the latched NEG.
- Left shift by n: result = operand << n; the bottom n bits are 0.
- SHAMT=0: RESULT = DATA_IN.
- START while BUSY=1 (in SHIFT or DONE_S): ignored; no queueing.
- A new START is accepted no earlier than the cycle after DONE.
- Inputs change after capture: no effect on the request in flight.
- RESULT updates only on the transition into DONE_S.

Optional Feature:
- Macro ITERATIVE_SHIFTER_ROTATE_EN.
- When defined:
  - Adds input port ROT (1 bit), captured on START.
  - ROT=1 rotates in the SH_DIR direction; NEG is ignored; bits leaving one end enter the other.
  - ROT=0 behaves exactly as without the macro.
- When undefined: no ROT port, shift-only behaviour.

Decomposition:
- Package shifter_pkg:
  - State enum: IDLE, SHIFT, DONE_S.
  - Constants SH_LEFT=1'b0 and SH_RIGHT=1'b1.
  - Default WIDTH localparam.
- Sub-module shift_stage_var, combinational:
  - Inputs: operand, stage index k, enable bit, direction, fill, and rotate (under the macro).
  - Output: operand shifted by 2^k, or passed through when enable=0.
- The top level holds the FSM, the capture registers and the stage counter.

Test Plan:
- Reset then idle: RST_n=0 mid-SHIFT → BUSY=0, DONE=0, RESULT=0 immediately; after release, START works normally.
- Left shift: DATA_IN=32'h0000_00F1, SH_DIR=0, SHAMT=4 → DONE in the cycle after the 5th post-START edge; RESULT=32'h0000_0F10.
- Right shift with NEG fill:
  - DATA_IN=32'h8000_0000, SH_DIR=1, NEG=1, SHAMT=31 → RESULT=32'hFFFF_FFFF.
  - Same operands with NEG=0 → RESULT=32'h0000_0001.
- SHAMT=0 and BUSY protection: DATA_IN=32'hDEAD_BEEF, then a second START with different data during SHIFT → RESULT=32'hDEAD_BEEF; exactly one DONE pulse; second request dropped.
- Back-to-back: START asserted in the cycle after DONE with SHAMT=16 left on 32'h0000_ABCD → RESULT=32'hABCD_0000; latency is identical to the first request.
- With ITERATIVE_SHIFTER_ROTATE_EN: ROT=1, SH_DIR=1, DATA_IN=32'h0000_0001, SHAMT=1 → RESULT=32'h8000_0000.
